// File: rtl/i2c_reg_bank_pkg.sv
// i2c_reg_bank_pkg: shared FSM states, protocol constants and sizing helper for the I2C register bank
package i2c_reg_bank_pkg;
  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;
  localparam int RW_BIT = 0;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int SYNC_DEPTH = 2;
  function automatic int total_regs(input int num_rw, input int num_ro);
    return num_rw + num_ro;
  endfunction
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions
module i2c_line_sync
  import i2c_reg_bank_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start,
  output logic stop
);
  logic [SYNC_DEPTH-1:0] scl_q, sda_q;
  logic scl_s, scl_d, sda_d;
  // Flops reset to the idle-bus level so no edge is invented on release
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      scl_q <= '1;
      sda_q <= '1;
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_q <= {scl_q[SYNC_DEPTH-2:0], scl_i};
      sda_q <= {sda_q[SYNC_DEPTH-2:0], sda_i};
      scl_d <= scl_s;
      sda_d <= sda_s;
    end
  assign scl_s = scl_q[SYNC_DEPTH-1];
  assign sda_s = sda_q[SYNC_DEPTH-1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start = scl_s & scl_d & sda_d & ~sda_s;
  assign stop = scl_s & scl_d & ~sda_d & sda_s;
endmodule

// File: rtl/i2c_reg_bank_target.sv
// i2c_reg_bank_target: I2C target exposing host-writable control bytes and read-only status bytes
module i2c_reg_bank_target
  import i2c_reg_bank_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h70,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 4,
  parameter logic [NUM_RW*8-1:0] RW_RESET = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_i,
  input  logic                sda_i,
  output logic                sda_oe,
  input  logic [NUM_RO*8-1:0] status_i,
  output logic [NUM_RW*8-1:0] regs_o,
  output logic                wr_strobe_o,
  output logic [7:0]          wr_addr_o,
  output logic                busy_o
);
  localparam logic [8:0] TOTAL = 9'(total_regs(NUM_RW, NUM_RO));
  localparam logic [8:0] RW_N = 9'(NUM_RW);
  state_t state, state_n;
  logic scl_rise, scl_fall, sda_s, start, stop;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shift, shift_n, ptr, ptr_n, ptr_inc, rd_byte;
  logic [6:0] shadow, shadow_n;
  logic oe_n, busy_n, commit, bit_in, byte_end, match, reg_ok;
  logic [7:0] bank [256];

  i2c_line_sync u_sync (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
    .scl_rise(scl_rise), .scl_fall(scl_fall), .sda_s(sda_s), .start(start), .stop(stop)
  );

  // Full 256-entry view so the 8-bit pointer indexes it without range logic
  for (genvar i = 0; i < 256; i++) begin : g_bank
    if (i < NUM_RW) begin : g_rw
      assign bank[i] = regs_o[i*8 +: 8];
    end else if (i < NUM_RW + NUM_RO) begin : g_ro
      assign bank[i] = status_i[(i-NUM_RW)*8 +: 8];
    end else begin : g_nil
      assign bank[i] = 8'h00;
    end
  end

  assign rd_byte = bank[ptr];
  assign ptr_inc = ({1'b0, ptr} == TOTAL - 9'd1) ? 8'd0 : ptr + 8'd1;
  assign bit_in = scl_rise && !cnt[3];
  assign byte_end = scl_fall && cnt[3];
  assign match = shift[7:1] == I2C_ADDR;
  assign reg_ok = {1'b0, shift} < TOTAL;

  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shift_n = shift;
    ptr_n = ptr;
    shadow_n = shadow;
    oe_n = sda_oe;
    busy_n = busy_o;
    commit = 1'b0;
    if (stop) begin
      state_n = IDLE;
      oe_n = 1'b0;
      busy_n = 1'b0;
    end else if (start) begin
      state_n = DEV_ADDR;
      cnt_n = '0;
      oe_n = 1'b0;
    end else begin
      if (bit_in && state inside {DEV_ADDR, REG_ADDR, WR_DATA, RD_DATA}) begin
        shift_n = {shift[6:0], sda_s};
        cnt_n = cnt + 4'd1;
      end
      case (state)
        DEV_ADDR: if (byte_end) begin
          state_n = match ? DEV_ACK : IDLE;
          oe_n = match;
          busy_n = match;
        end
        DEV_ACK: if (scl_fall) begin
          state_n = shift[RW_BIT] ? RD_DATA : REG_ADDR;
          cnt_n = '0;
          shadow_n = rd_byte[6:0];
          oe_n = shift[RW_BIT] && !rd_byte[7];
        end
        REG_ADDR: if (byte_end) begin
          state_n = reg_ok ? REG_ACK : IDLE;
          oe_n = reg_ok;
          ptr_n = reg_ok ? shift : ptr;
        end
        REG_ACK: if (scl_fall) begin
          state_n = WR_DATA;
          cnt_n = '0;
          oe_n = 1'b0;
        end
        WR_DATA: if (byte_end) begin
          state_n = WR_ACK;
          oe_n = 1'b1;
        end
        WR_ACK: begin
          if (scl_rise) begin
            commit = {1'b0, ptr} < RW_N;
            ptr_n = ptr_inc;
          end
          if (scl_fall) begin
            state_n = WR_DATA;
            cnt_n = '0;
            oe_n = 1'b0;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (cnt[3]) begin
            state_n = RD_ACK;
            cnt_n = '0;
          end
          shadow_n = {shadow[5:0], 1'b0};
          oe_n = !cnt[3] && !shadow[6];
        end
        RD_ACK: begin
          if (scl_rise) begin
            state_n = sda_s == NACK ? IDLE : RD_ACK;
            ptr_n = sda_s == ACK ? ptr_inc : ptr;
          end
          if (scl_fall) begin
            state_n = RD_DATA;
            cnt_n = '0;
            shadow_n = rd_byte[6:0];
            oe_n = !rd_byte[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shift <= '0;
      ptr <= '0;
      shadow <= '0;
      sda_oe <= 1'b0;
      busy_o <= 1'b0;
      wr_strobe_o <= 1'b0;
      wr_addr_o <= '0;
      regs_o <= RW_RESET;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shift <= shift_n;
      ptr <= ptr_n;
      shadow <= shadow_n;
      sda_oe <= oe_n;
      busy_o <= busy_n;
      wr_strobe_o <= commit;
      if (commit) begin
        wr_addr_o <= ptr;
        for (int k = 0; k < NUM_RW; k++)
          if (ptr == 8'(k)) regs_o[k*8 +: 8] <= shift;
      end
    end
endmodule

// File: tb/tb_i2c_reg_bank_target.sv
// tb_i2c_reg_bank_target: open-drain master model with scoreboard queues for reads and write strobes
module tb_i2c_reg_bank_target;
  localparam logic [63:0] RST_IMG = 64'h0807_0605_0403_0201;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic sda_oe, wr_strobe_o, busy_o, sda_line;
  logic [7:0] wr_addr_o;
  logic [63:0] regs_o;
  logic [31:0] status_i = 32'h4433_225A;
  logic [63:0] m_regs;
  logic [7:0] m_ptr;
  logic [15:0] wq[$];
  logic [7:0] rq[$];
  int n_cmp = 0, n_err = 0;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_reg_bank_target #(.I2C_ADDR(7'h70), .NUM_RW(8), .NUM_RO(4), .RW_RESET(RST_IMG)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_line), .sda_oe(sda_oe),
    .status_i(status_i), .regs_o(regs_o), .wr_strobe_o(wr_strobe_o),
    .wr_addr_o(wr_addr_o), .busy_o(busy_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (wr_strobe_o) begin
      check("strobe_expected", wq.size() != 0, 1'b1);
      if (wq.size() != 0) check("strobe", {wr_addr_o, regs_o[wr_addr_o*8 +: 8]}, wq.pop_front());
    end

  task automatic q_wait();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic r);
    sda_m = b;
    q_wait();
    scl = 1'b1;
    q_wait();
    r = sda_line;
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    q_wait();
    scl = 1'b1;
    q_wait();
    sda_m = 1'b0;
    q_wait();
    scl = 1'b0;
    q_wait();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    q_wait();
    scl = 1'b1;
    q_wait();
    sda_m = 1'b1;
    q_wait();
  endtask

  task automatic send(input string tag, input logic [7:0] d, input logic exp_ack);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    check(tag, !r, exp_ack);
  endtask

  task automatic set_reg(input logic [7:0] a);
    send("reg_ack", a, a < 8'd12);
    if (a < 8'd12) m_ptr = a;
  endtask

  task automatic wr_data(input logic [7:0] d);
    if (m_ptr < 8'd8) begin
      wq.push_back({m_ptr, d});
      m_regs[m_ptr*8 +: 8] = d;
    end
    send("data_ack", d, 1'b1);
    m_ptr = (m_ptr == 8'd11) ? 8'd0 : m_ptr + 8'd1;
  endtask

  task automatic rd_data(input logic nack);
    logic [7:0] d;
    logic r;
    rq.push_back(m_ptr < 8'd8 ? m_regs[m_ptr*8 +: 8] : status_i[(m_ptr-8)*8 +: 8]);
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(nack, r);
    check("rd_data", d, rq.pop_front());
    if (!nack) m_ptr = (m_ptr == 8'd11) ? 8'd0 : m_ptr + 8'd1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic r;
    logic [7:0] d;
    m_regs = RST_IMG;
    m_ptr = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_oe", sda_oe, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_strobe", wr_strobe_o, 1'b0);
    check("rst_wr_addr", wr_addr_o, 8'h00);
    check("rst_regs", regs_o, RST_IMG);
    rst = 1'b0;
    q_wait();
    // burst write into regs 2,3
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    check("busy_hi", busy_o, 1'b1);
    set_reg(8'h02);
    wr_data(8'hA5);
    wr_data(8'h3C);
    bus_stop();
    check("regs_burst", regs_o, m_regs);
    check("busy_lo", busy_o, 1'b0);
    // pointer set, repeated START, 3-byte read
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h01);
    bus_start();
    send("dev_ack_r", 8'hE1, 1'b1);
    rd_data(1'b0);
    rd_data(1'b0);
    rd_data(1'b1);
    check("nack_release", sda_oe, 1'b0);
    bus_stop();
    check("busy_lo_rd", busy_o, 1'b0);
    // status read, then discarded write to a status address
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h08);
    bus_start();
    send("dev_ack_r", 8'hE1, 1'b1);
    rd_data(1'b1);
    bus_stop();
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h08);
    wr_data(8'hFF);
    bus_stop();
    check("regs_ro_write", regs_o, m_regs);
    // wrong device address, then current-address read shows pointer kept
    bus_start();
    send("dev_nomatch", 8'hE2, 1'b0);
    check("nomatch_oe", sda_oe, 1'b0);
    check("nomatch_busy", busy_o, 1'b0);
    bus_stop();
    bus_start();
    send("dev_ack_r", 8'hE1, 1'b1);
    rd_data(1'b1);
    bus_stop();
    // out-of-range register address, then wrap from the last register
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h0C);
    bus_stop();
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h0B);
    bus_start();
    send("dev_ack_r", 8'hE1, 1'b1);
    rd_data(1'b0);
    rd_data(1'b1);
    bus_stop();
    // reset while the data-byte ACK is driven
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h00);
    d = 8'h99;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    check("ack_drive", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    check("rst_async_oe", sda_oe, 1'b0);
    check("rst_mid_regs", regs_o, RST_IMG);
    check("rst_mid_busy", busy_o, 1'b0);
    m_regs = RST_IMG;
    m_ptr = 8'd0;
    q_wait();
    rst = 1'b0;
    q_wait();
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h04);
    wr_data(8'h77);
    bus_start();
    send("dev_ack_w", 8'hE0, 1'b1);
    set_reg(8'h04);
    bus_start();
    send("dev_ack_r", 8'hE1, 1'b1);
    rd_data(1'b0);
    rd_data(1'b1);
    bus_stop();
    check("regs_final", regs_o, m_regs);
    check("strobes_drained", wq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_reg_bank_target.md
# i2c_reg_bank_target

Parametrised I2C target with an integrated register bank: next-generation replacement for the fixed 8-register I2C path of the SPI/I2C register-bank project. A configurable number of host-writable control registers and read-only status registers sits behind one 7-bit device address. The block supports auto-increment bursts, repeated START and a read-data shadow. It connects directly to the top-level uio pins: SDA is open-drain via an output enable, SCL is input-only.

## Interface
- `I2C_ADDR`, default 7'h70: 7-bit device address.
- `NUM_RW`, default 8: control registers, 1..128.
- `NUM_RO`, default 4: status registers, 0..128; total `NUM_RW+NUM_RO` must be ≤ 256.
- `RW_RESET`, default all zeros: flat `NUM_RW*8` reset image for the control registers.
- `clk`  in  1  system clock; frequency ≥ 16× SCL.
- `rst`  in  1  asynchronous, active-high reset.
- `scl_i`  in  1  raw SCL pin, asynchronous.
- `sda_i`  in  1  raw SDA pin, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release. The pin output value is tied 0 outside this block.
- `status_i`  in  `NUM_RO*8`  status bytes; byte k is register address `NUM_RW+k`.
- `regs_o`  out  `NUM_RW*8`  control register contents; byte k is register address k.
- `wr_strobe_o`  out  1  one-cycle pulse when a control register is updated.
- `wr_addr_o`  out  8  address written, valid with the strobe.
- `busy_o`  out  1  high from an address-matched START until STOP.

## Operation
- Input conditioning: 2-flop synchroniser on SCL and SDA, then a 1-cycle edge detector.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- IDLE to DEV_ADDR on START.
- DEV_ADDR shifts 8 bits in on SCL rise.
  - Match with R/W=0: DEV_ACK, then REG_ADDR.
  - Match with R/W=1: DEV_ACK, then RD_DATA.
  - Mismatch: IDLE, SDA never driven.
- REG_ADDR:
  - Byte < `NUM_RW+NUM_RO`: ACK and load the pointer.
  - Otherwise: NACK, pointer unchanged, then IDLE.
- WR_DATA: after 8 bits, ACK unconditionally. At the ACK, if pointer < `NUM_RW`, update the register and pulse the strobe. A write to a status address is ACKed and discarded. The pointer then increments.
- RD_DATA: at the SCL fall that starts the byte, a shadow byte is loaded from the register or status byte at the pointer. The shadow is shifted MSB first.
  - RD_ACK samples the master's bit.
  - ACK (0): increment the pointer, continue RD_DATA.
  - NACK (1): release SDA, go to IDLE.
- Pointer wraps from `NUM_RW+NUM_RO-1` to 0.
- The pointer persists across transactions and repeated STARTs. It resets to 0.
- Repeated START in any state: go to DEV_ADDR and release SDA.
- STOP in any state: go to IDLE, release SDA, clear `busy_o`.
- Reset values:
  - FSM IDLE, pointer 0.
  - `regs_o` = `RW_RESET`.
  - `sda_oe`, `wr_strobe_o`, `busy_o` = 0; `wr_addr_o` = 0.
- Reset mid-transaction: SDA is released immediately (async). The block resumes only at the next START.

## Timing
- Synchroniser plus edge detect: an SCL/SDA edge is acted on 3 clk cycles after the pin changes.
- `sda_oe` changes only in the cycle after a detected SCL fall, never while SCL is high. START and STOP are therefore never corrupted by the target.
- ACK drive is held from the SCL fall after bit 8 until the next SCL fall.
- `regs_o` and `wr_strobe_o` update in the same cycle, one cycle after the SCL rise of the ACK bit.
- `status_i` is sampled once per read byte, at shadow load; later changes do not tear the byte.
- Simultaneous START detection and a pending write commit: the commit completes only if the ACK bit has already been clocked; otherwise the data is dropped.

## Structure
- Package `i2c_reg_bank_pkg` holds:
  - the FSM state enum;
  - the R/W bit position, ACK/NACK constants and synchroniser depth;
  - a function computing the total register count.
- Sub-module `i2c_line_sync` holds the synchronisers, the edge detect and START/STOP detect. Outputs: `scl_rise`, `scl_fall`, `sda_s`, `start`, `stop`.
- The top holds the FSM, bit counter, shift register, pointer and register array.

## Test plan
- Write 0x70/W, reg 0x02, data 0xA5,0x3C, STOP → `regs_o` bytes 2,3 = 0xA5,0x3C; two strobes, addr 2 then 3; each data byte ACKed.
- Write reg 0x01, repeated START, 0x70/R, read 3 bytes, NACK last → SDA returns regs 1,2,3; SDA released after the NACK; `busy_o` low after STOP.
- `status_i` byte0=0x5A; read from reg 0x08 (`NUM_RW`=8) → 0x5A. Write 0xFF to 0x08 → ACKed, no strobe, `regs_o` unchanged.
- Address 0x71 → no ACK (SDA released on the 9th clock), FSM idle, pointer unchanged.
- Reg address 0x0C (≥ 12 total) → NACK. Burst from 0x0B reading 2 bytes → data from regs 11 then 0 (wrap).
- Assert `rst` mid-data-byte while ACK is driven → `sda_oe`=0 immediately, `regs_o`=`RW_RESET`; the next full transaction succeeds.
